// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven time-setting FSM with field adjust auto-repeat,
// idle timeout back to RUN, blink phase and zero-time request.
module clock_set_ctrl #(
  parameter int HOLD_DELAY    = 500,
  parameter int REPEAT_PERIOD = 100,
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_zero,
  output logic       keep,
  output logic       adjust_sec,
  output logic       adjust_min,
  output logic       adjust_hour,
  output logic       clr_time,
  output logic [1:0] mode,
  output logic       blink
);
  localparam int HW = $clog2(HOLD_DELAY + 1);
  localparam int RW = $clog2(REPEAT_PERIOD + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_DELAY);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS - 1);
  typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3} state_t;
  state_t        state_q, state_d;
  logic          mode_prev_q, inc_prev_q, zero_prev_q;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [TW-1:0] to_q, to_d;
  logic          keep_q, keep_d, blink_q, blink_d, clr_time_q, clr_time_d;
  logic          adjust_sec_q, adjust_sec_d, adjust_min_q, adjust_min_d, adjust_hour_q, adjust_hour_d;
  logic          mode_edge, inc_edge, zero_edge, any_edge, setting, timeout, changed, held, fire;
  always_comb begin
    mode_edge     = btn_mode & ~mode_prev_q;
    inc_edge      = btn_inc & ~inc_prev_q;
    zero_edge     = btn_zero & ~zero_prev_q;
    any_edge      = mode_edge | inc_edge | zero_edge;
    setting       = state_q != RUN;
    timeout       = setting & tick & ~any_edge & (to_q >= TO_LAST);
    state_d       = mode_edge ? state_t'(state_q + 2'd1) : timeout ? RUN : state_q;
    changed       = state_d != state_q;
    // a hold only counts if it started with an edge inside the current SET state
    held          = setting & btn_inc & inc_prev_q & (hold_q != '0) & ~changed;
    fire          = (inc_edge & setting & ~changed) | (held & (hold_q == HOLD_MAX) & (rep_q == '0));
    hold_d        = (inc_edge & setting & ~changed) ? HW'(1) :
                    held ? ((hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1)) : '0;
    rep_d         = (held & (hold_q == HOLD_MAX)) ? ((rep_q == REP_LAST) ? '0 : rep_q + RW'(1)) : '0;
    to_d          = (setting & ~changed) ? (any_edge ? '0 : tick ? to_q + TW'(1) : to_q) : '0;
    keep_d        = state_d != RUN;
    blink_d       = (state_d == RUN) ? 1'b0 : changed ? 1'b1 : blink_q ^ tick;
    clr_time_d    = zero_edge;
    adjust_hour_d = fire & (state_q == SET_HOUR);
    adjust_min_d  = fire & (state_q == SET_MIN);
    adjust_sec_d  = fire & (state_q == SET_SEC);
  end
  // previous-sample flops reset high so a button held through clear is not an edge
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q       <= RUN;
      mode_prev_q   <= 1'b1;
      inc_prev_q    <= 1'b1;
      zero_prev_q   <= 1'b1;
      hold_q        <= '0;
      rep_q         <= '0;
      to_q          <= '0;
      keep_q        <= 1'b0;
      blink_q       <= 1'b0;
      clr_time_q    <= 1'b0;
      adjust_hour_q <= 1'b0;
      adjust_min_q  <= 1'b0;
      adjust_sec_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_prev_q   <= btn_mode;
      inc_prev_q    <= btn_inc;
      zero_prev_q   <= btn_zero;
      hold_q        <= hold_d;
      rep_q         <= rep_d;
      to_q          <= to_d;
      keep_q        <= keep_d;
      blink_q       <= blink_d;
      clr_time_q    <= clr_time_d;
      adjust_hour_q <= adjust_hour_d;
      adjust_min_q  <= adjust_min_d;
      adjust_sec_q  <= adjust_sec_d;
    end
  end
  assign mode        = state_q;
  assign keep        = keep_q;
  assign blink       = blink_q;
  assign clr_time    = clr_time_q;
  assign adjust_hour = adjust_hour_q;
  assign adjust_min  = adjust_min_q;
  assign adjust_sec  = adjust_sec_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed and random stimulus against a behavioural model
// that tracks press age and idle tick count arithmetically.
module tb_clock_set_ctrl;
  localparam int HD = 8, RP = 4, TO = 3;
  logic clk = 0, clear = 1, tick = 0, btn_mode = 0, btn_inc = 0, btn_zero = 0;
  logic keep, adjust_sec, adjust_min, adjust_hour, clr_time, blink;
  logic [1:0] mode;
  int vectors = 0, miscompares = 0, cyc_n = 0;
  int m_mode, m_age, m_idle;
  bit m_blink, m_keep, m_as, m_am, m_ah, m_clr;
  bit m_low[3];
  int hits[$];
  int exp_hits[4] = '{1, 9, 13, 17};
  int n;

  clock_set_ctrl #(.HOLD_DELAY(HD), .REPEAT_PERIOD(RP), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .clear(clear), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .btn_zero(btn_zero), .keep(keep), .adjust_sec(adjust_sec), .adjust_min(adjust_min),
    .adjust_hour(adjust_hour), .clr_time(clr_time), .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_mode = 0; m_age = -1; m_idle = 0;
    m_blink = 0; m_keep = 0; m_as = 0; m_am = 0; m_ah = 0; m_clr = 0;
    m_low = '{0, 0, 0};
  endfunction

  // m_age: cycles since the press that started the current valid hold, -1 if none
  function automatic void model_step();
    bit b[3], e[3];
    bit any_e, chg, f;
    int nm, a;
    b = '{btn_mode, btn_inc, btn_zero};
    for (int k = 0; k < 3; k++) e[k] = b[k] && m_low[k];
    any_e = e[0] || e[1] || e[2];
    nm = e[0] ? (m_mode + 1) % 4 :
         (m_mode != 0 && tick && !any_e && m_idle + 1 >= TO) ? 0 : m_mode;
    chg = nm != m_mode;
    f = 0;
    a = -1;
    if (!chg && m_mode != 0 && btn_inc) begin
      if (e[1]) begin
        a = 0;
        f = 1;
      end else if (m_age >= 0) begin
        a = m_age + 1;
        f = a >= HD && (a - HD) % RP == 0;
      end
    end
    m_ah = f && m_mode == 1;
    m_am = f && m_mode == 2;
    m_as = f && m_mode == 3;
    m_idle = (chg || any_e || nm == 0) ? 0 : m_idle + int'(tick);
    m_blink = nm == 0 ? 0 : chg ? 1 : m_blink ^ tick;
    m_keep = nm != 0;
    m_clr = e[2];
    m_mode = nm;
    m_age = a;
    for (int k = 0; k < 3; k++) m_low[k] = !b[k];
  endfunction

  task automatic check(input string tag);
    logic [7:0] got, exp;
    got = {keep, adjust_hour, adjust_min, adjust_sec, clr_time, mode, blink};
    exp = {m_keep, m_ah, m_am, m_as, m_clr, 2'(m_mode), m_blink};
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s cycle %0d got %b exp %b (keep,ah,am,as,clr,mode,blink)", tag, cyc_n, got, exp);
    end
  endtask

  task automatic expect_eq(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // called at a negedge; leaves at the next negedge with outputs checked #1 after posedge
  task automatic cyc(input bit tk, input bit bm, input bit bi, input bit bz);
    tick = tk; btn_mode = bm; btn_inc = bi; btn_zero = bz;
    @(posedge clk);
    if (!clear) model_step();
    cyc_n++;
    #1 check("cyc");
    @(negedge clk);
  endtask

  task automatic press_mode();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset");
    @(negedge clk);
    clear = 0;
    cyc(0, 0, 0, 0);

    for (int p = 1; p <= 4; p++) begin
      cyc(0, 1, 0, 0);
      expect_eq("mode_press", int'(mode), p % 4);
      expect_eq("keep_press", int'(keep), int'(p != 4));
      cyc(0, 0, 0, 0);
    end

    press_mode(); press_mode();
    cyc(0, 0, 1, 0);
    expect_eq("inc_min_pulse", int'({adjust_hour, adjust_min, adjust_sec}), 3'b010);
    cyc(0, 0, 0, 0);
    expect_eq("inc_min_once", int'(adjust_min), 0);

    press_mode();
    for (int k = 0; k < 26; k++) begin
      cyc(0, 0, k < 20, 0);
      if (adjust_sec) hits.push_back(k + 1);
    end
    expect_eq("repeat_count", hits.size(), 4);
    for (int i = 0; i < 4; i++) expect_eq("repeat_at", i < hits.size() ? hits[i] : -1, exp_hits[i]);

    press_mode();
    cyc(0, 0, 0, 1);
    expect_eq("zero_run_clr", int'(clr_time), 1);
    expect_eq("zero_run_mode", int'(mode), 0);
    cyc(0, 0, 0, 0);
    expect_eq("zero_run_1cyc", int'(clr_time), 0);
    press_mode(); press_mode();
    cyc(0, 0, 0, 1);
    expect_eq("zero_min_clr", int'(clr_time), 1);
    expect_eq("zero_min_mode", int'(mode), 2);
    cyc(0, 0, 0, 0);
    expect_eq("zero_min_1cyc", int'(clr_time), 0);

    press_mode(); press_mode(); press_mode();
    for (int t = 1; t <= 3; t++) begin
      cyc(1, 0, 0, 0);
      expect_eq("timeout_tick", int'(mode), t < 3 ? 1 : 0);
      cyc(0, 0, 0, 0);
    end
    press_mode();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 0);
    expect_eq("tick_inc_wins", int'(mode), 1);
    cyc(0, 0, 0, 0);
    for (int t = 1; t <= 3; t++) begin
      cyc(1, 0, 0, 0);
      expect_eq("timeout_restart", int'(mode), t < 3 ? 1 : 0);
      cyc(0, 0, 0, 0);
    end

    press_mode(); press_mode(); press_mode();
    for (int k = 0; k < 9; k++) cyc(0, 0, 1, 0);
    expect_eq("pulse_before_clear", int'(adjust_sec), 1);
    #2 clear = 1;
    #1 model_reset();
    check("async_clear");
    @(negedge clk);
    cyc(0, 1, 1, 0);
    clear = 0;
    for (int k = 0; k < 5; k++) cyc(0, 1, 1, 0);
    expect_eq("held_through_clear", int'(mode), 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    expect_eq("fresh_edge_after_clear", int'(mode), 1);
    n = 0;
    for (int k = 0; k < 15; k++) begin
      cyc(0, 0, 1, 0);
      n += int'(adjust_hour);
    end
    expect_eq("no_pulse_after_clear", n, 0);
    cyc(0, 0, 0, 0);

    for (int k = 0; k < 800; k++)
      cyc($urandom_range(3) == 0, $urandom_range(7) == 0 ? ~btn_mode : btn_mode,
          $urandom_range(15) == 0 ? ~btn_inc : btn_inc, $urandom_range(11) == 0 ? ~btn_zero : btn_zero);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
